// File: rtl/adc_capture_ctrl.sv
// Triggered capture sequencer: arms, waits for a trigger, then streams decimated
// {timestamp, sample} words into the sample RAM starting at address 0.
module adc_capture_ctrl #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned TS_W   = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   abort,
  input  logic [1:0]             trig_mode,
  input  logic                   sw_trig,
  input  logic                   ext_trig,
  input  logic [DATA_W-1:0]      threshold,
  input  logic [ADDR_W-1:0]      capture_len,
  input  logic [7:0]             decim,
  input  logic [DATA_W-1:0]      ad_data,
  input  logic [TS_W-1:0]        ad_time,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W+TS_W-1:0] wr_data,
  output logic [TS_W-1:0]        trig_time,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [DATA_W-1:0]       thr_q, thr_d;
  logic [ADDR_W-1:0]       len_q, len_d;
  logic [7:0]              decim_q, decim_d;
  logic [DATA_W-1:0]       prev_q, prev_d;
  logic                    prev_valid_q, prev_valid_d;
  logic [7:0]              dcnt_q, dcnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W+TS_W-1:0]  wr_data_q, wr_data_d;
  logic [TS_W-1:0]         trig_time_q, trig_time_d;

  logic                    trig_hit;
  logic [ADDR_W-1:0]       last_addr;
  logic [ADDR_W-1:0]       next_addr;

  // len = 0 wraps to all-ones here, which is exactly the 2**ADDR_W case.
  assign last_addr = len_q - ADDR_W'(1);
  assign next_addr = wr_addr_q + ADDR_W'(1);

  // Threshold modes need a primed previous sample; first ARMED cycle cannot fire them.
  always_comb begin
    trig_hit = 1'b0;
    case (mode_q)
      2'd0:    trig_hit = sw_trig;
      2'd1:    trig_hit = prev_valid_q && (prev_q < thr_q) && (ad_data >= thr_q);
      2'd2:    trig_hit = prev_valid_q && (prev_q > thr_q) && (ad_data <= thr_q);
      2'd3:    trig_hit = ext_trig;
      default: trig_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    thr_d        = thr_q;
    len_d        = len_q;
    decim_d      = decim_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    dcnt_d       = dcnt_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    trig_time_d  = trig_time_q;

    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (arm) begin
            state_d      = StArmed;
            mode_d       = trig_mode;
            thr_d        = threshold;
            len_d        = capture_len;
            decim_d      = decim;
            prev_valid_d = 1'b0;
          end
        end
        StArmed: begin
          prev_d       = ad_data;
          prev_valid_d = 1'b1;
          if (trig_hit) begin
            // The trigger sample itself is always stored at address 0.
            state_d     = (last_addr == '0) ? StDone : StCapture;
            trig_time_d = ad_time;
            dcnt_d      = '0;
            wr_en_d     = 1'b1;
            wr_addr_d   = '0;
            wr_data_d   = {ad_time, ad_data};
          end
        end
        StCapture: begin
          if (dcnt_q == decim_q) begin
            dcnt_d    = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = next_addr;
            wr_data_d = {ad_time, ad_data};
            if (next_addr == last_addr) begin
              state_d = StDone;
            end
          end else begin
            dcnt_d = dcnt_q + 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      mode_q       <= '0;
      thr_q        <= '0;
      len_q        <= '0;
      decim_q      <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      dcnt_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      trig_time_q  <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      thr_q        <= thr_d;
      len_q        <= len_d;
      decim_q      <= decim_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      dcnt_q       <= dcnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      trig_time_q  <= trig_time_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign trig_time = trig_time_q;
  assign busy      = (state_q == StArmed) || (state_q == StCapture);
  assign done      = (state_q == StDone);
  assign state     = state_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl; expected RAM writes are queued as stimulus
// is driven and popped whenever the DUT strobes wr_en.
module tb_adc_capture_ctrl;
  localparam int DW = 12;
  localparam int TW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    trig_mode = 2'd0;
  logic          sw_trig = 1'b0;
  logic          ext_trig = 1'b0;
  logic [DW-1:0] threshold = '0;
  logic [AW-1:0] capture_len = '0;
  logic [7:0]    decim = '0;
  logic [DW-1:0] ad_data = '0;
  logic [TW-1:0] ad_time = 32'h0000_1000;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW+TW-1:0] wr_data;
  logic [TW-1:0]    trig_time;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [DW+TW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            vec = 0;
  int            miss = 0;
  logic [TW-1:0] t_exp;

  adc_capture_ctrl #(
    .DATA_W (DW),
    .TS_W   (TW),
    .ADDR_W (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .abort       (abort),
    .trig_mode   (trig_mode),
    .sw_trig     (sw_trig),
    .ext_trig    (ext_trig),
    .threshold   (threshold),
    .capture_len (capture_len),
    .decim       (decim),
    .ad_data     (ad_data),
    .ad_time     (ad_time),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .trig_time   (trig_time),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a);
    exp_t e;
    e.addr = a;
    e.data = {ad_time, ad_data};
    exp_q.push_back(e);
  endtask

  // One clock; sample registered outputs just after the edge, then advance time.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check("spurious_wr", 64'(wr_en), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
    ad_time = ad_time + 32'd1;
  endtask

  task automatic drain_check(input string tag);
    check(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Arm, then scramble the config inputs so a missing latch shows up.
  task automatic do_arm(input logic [1:0] m, input int thr, input int len, input int dec);
    trig_mode   = m;
    threshold   = DW'(thr);
    capture_len = AW'(len);
    decim       = 8'(dec);
    arm         = 1'b1;
    tick();
    arm         = 1'b0;
    trig_mode   = ~m;
    threshold   = ~threshold;
    capture_len = capture_len + 4'd5;
    decim       = decim + 8'd7;
    check("armed_state", 64'(state), 64'd1);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_trig_time", 64'(trig_time), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    tick();

    // Software trigger, len 4, no decimation
    do_arm(2'd0, 0, 4, 0);
    ad_data = 12'd100;
    sw_trig = 1'b1;
    expect_wr(4'd0);
    t_exp = ad_time;
    tick();
    sw_trig = 1'b0;
    check("t1_state_cap", 64'(state), 64'd2);
    check("t1_busy", 64'(busy), 64'd1);
    for (int i = 1; i < 4; i++) begin
      ad_data = DW'(100 + i);
      expect_wr(AW'(i));
      tick();
    end
    check("t1_state_done", 64'(state), 64'd3);
    check("t1_done", 64'(done), 64'd1);
    check("t1_busy_low", 64'(busy), 64'd0);
    check("t1_trig_time", 64'(trig_time), 64'(t_exp));
    ad_data = 12'd104;
    tick();
    tick();
    drain_check("t1_drain");

    // Rising threshold crossing
    do_arm(2'd1, 2048, 2, 0);
    ad_data = 12'd2040;
    tick();
    ad_data = 12'd2045;
    tick();
    check("t2_no_early_trig", 64'(state), 64'd1);
    ad_data = 12'd2050;
    expect_wr(4'd0);
    t_exp = ad_time;
    tick();
    check("t2_state_cap", 64'(state), 64'd2);
    ad_data = 12'd2060;
    expect_wr(4'd1);
    tick();
    check("t2_state_done", 64'(state), 64'd3);
    check("t2_trig_time", 64'(trig_time), 64'(t_exp));
    drain_check("t2_drain");

    // Falling crossing landing exactly on threshold, single-sample capture
    do_arm(2'd2, 1000, 1, 0);
    ad_data = 12'd1010;
    tick();
    ad_data = 12'd1005;
    tick();
    check("t2b_armed", 64'(state), 64'd1);
    ad_data = 12'd1000;
    expect_wr(4'd0);
    t_exp = ad_time;
    tick();
    check("t2b_done", 64'(state), 64'd3);
    check("t2b_trig_time", 64'(trig_time), 64'(t_exp));
    tick();
    drain_check("t2b_drain");

    // Above threshold from the first ARMED cycle: never fires
    do_arm(2'd1, 2048, 4, 0);
    ad_data = 12'd3000;
    repeat (10) tick();
    check("t3_still_armed", 64'(state), 64'd1);
    check("t3_no_write", 64'(wr_en), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_abort_idle", 64'(state), 64'd0);
    check("t3_abort_busy", 64'(busy), 64'd0);
    drain_check("t3_drain");

    // Decimation by 3, arm during CAPTURE ignored
    do_arm(2'd0, 0, 3, 2);
    ad_data = 12'd10;
    sw_trig = 1'b1;
    expect_wr(4'd0);
    tick();
    sw_trig = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      ad_data = DW'(10 + i);
      if (i % 3 == 0) expect_wr(AW'(i / 3));
      if (i == 2) arm = 1'b1;
      tick();
      arm = 1'b0;
      if (i == 2) check("t4_arm_ignored", 64'(state), 64'd2);
    end
    check("t4_done", 64'(done), 64'd1);
    tick();
    tick();
    drain_check("t4_drain");

    // len = 0 means full depth; external trigger
    do_arm(2'd3, 0, 0, 0);
    ext_trig = 1'b1;
    ad_data = 12'd200;
    expect_wr(4'd0);
    tick();
    for (int i = 1; i < 16; i++) begin
      ad_data = DW'(200 + i);
      expect_wr(AW'(i));
      tick();
    end
    check("t5_done", 64'(state), 64'd3);
    check("t5_last_addr", 64'(wr_addr), 64'd15);
    tick();
    tick();
    ext_trig = 1'b0;
    drain_check("t5_drain");

    // Abort after two of eight writes
    do_arm(2'd0, 0, 8, 0);
    ad_data = 12'd50;
    sw_trig = 1'b1;
    expect_wr(4'd0);
    tick();
    sw_trig = 1'b0;
    ad_data = 12'd51;
    expect_wr(4'd1);
    tick();
    abort = 1'b1;
    ad_data = 12'd52;
    tick();
    abort = 1'b0;
    check("t6_wr_en", 64'(wr_en), 64'd0);
    check("t6_state", 64'(state), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    tick();
    drain_check("t6_drain");

    // Abort beats a same-cycle trigger, and beats arm in IDLE
    do_arm(2'd0, 0, 8, 0);
    sw_trig = 1'b1;
    abort = 1'b1;
    tick();
    sw_trig = 1'b0;
    check("t6b_no_write", 64'(wr_en), 64'd0);
    check("t6b_state", 64'(state), 64'd0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    check("t6c_abort_beats_arm", 64'(state), 64'd0);
    drain_check("t6_drain2");

    // Asynchronous reset mid-capture
    do_arm(2'd0, 0, 8, 0);
    ad_data = 12'd70;
    sw_trig = 1'b1;
    expect_wr(4'd0);
    tick();
    sw_trig = 1'b0;
    ad_data = 12'd71;
    expect_wr(4'd1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("t7_wr_en", 64'(wr_en), 64'd0);
    check("t7_wr_addr", 64'(wr_addr), 64'd0);
    check("t7_wr_data", 64'(wr_data), 64'd0);
    check("t7_trig_time", 64'(trig_time), 64'd0);
    check("t7_state", 64'(state), 64'd0);
    check("t7_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("t7_idle_after", 64'(state), 64'd0);
    drain_check("t7_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
